// File: rtl/divide10_pkg.sv
// Shared constants and types for the divide-by-10 unit.
//   DIVISOR      fixed divisor (10)
//   DIVIDEND_W   operand width
//   QUOTIENT_W   quotient width (also the number of serial steps)
//   REMAINDER_W  remainder / working register width
//   STEP_W       width of the step index k
//   state_e      control FSM states
package divide10_pkg;

    localparam int unsigned DIVISOR     = 10;
    localparam int unsigned DIVIDEND_W  = 14;
    localparam int unsigned QUOTIENT_W  = 10;
    localparam int unsigned REMAINDER_W = 14;
    localparam int unsigned STEP_W      = 4;

    // Index of the first (most significant) quotient step.
    localparam logic [STEP_W-1:0] FIRST_STEP = STEP_W'(QUOTIENT_W - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Divisor aligned to quotient bit k. 10 << 9 = 5120 still fits in the
    // working register, so no overflow bit is needed.
    function automatic logic [REMAINDER_W-1:0] shifted_divisor(input logic [STEP_W-1:0] k);
        return REMAINDER_W'(DIVISOR) << k;
    endfunction

endpackage

// File: rtl/divide10_step.sv
// One restoring division step: compare the working remainder against the
// divisor aligned to quotient bit k and subtract when it fits.
//   w_cur   current working remainder
//   step    quotient bit index k (0..9)
//   w_next  working remainder after this step
//   q_bit   quotient bit k produced by this step
module divide10_step
    import divide10_pkg::*;
(
    input  logic [REMAINDER_W-1:0] w_cur,
    input  logic [STEP_W-1:0]      step,
    output logic [REMAINDER_W-1:0] w_next,
    output logic                   q_bit
);

    logic [REMAINDER_W-1:0] sub;

    always_comb begin
        sub    = shifted_divisor(step);
        q_bit  = (w_cur >= sub);
        w_next = q_bit ? (w_cur - sub) : w_cur;
    end

endmodule

// File: rtl/divide_10.sv
// Multi-cycle unsigned divide-by-10. A start pulse in idle captures the
// dividend; ten serial restoring steps (k = 9..0) follow, then quotient and
// remainder are registered and done is raised for one cycle.
// Dividends above 10239 saturate the quotient at 1023, with the excess left
// in the remainder so quotient*10 + remainder == dividend always holds.
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      launch request, only honoured in idle
//   dividend   14-bit unsigned operand, captured at launch
//   quotient   10-bit registered result
//   remainder  14-bit registered result
//   done       one-cycle flag marking fresh results
module divide_10
    import divide10_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIVIDEND_W-1:0]  dividend,
    output logic [QUOTIENT_W-1:0]  quotient,
    output logic [REMAINDER_W-1:0] remainder,
    output logic                   done
);

    state_e                 state_q, state_d;
    logic [REMAINDER_W-1:0] w_q, w_d;
    logic [QUOTIENT_W-1:0]  qw_q, qw_d;
    logic [STEP_W-1:0]      k_q, k_d;
    logic [QUOTIENT_W-1:0]  quotient_q, quotient_d;
    logic [REMAINDER_W-1:0] remainder_q, remainder_d;

    logic [REMAINDER_W-1:0] w_step;
    logic                   q_bit;

    divide10_step u_step (
        .w_cur  (w_q),
        .step   (k_q),
        .w_next (w_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            w_q         <= '0;
            qw_q        <= '0;
            k_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            qw_q        <= qw_d;
            k_q         <= k_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        qw_d        = qw_q;
        k_d         = k_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d     = REMAINDER_W'(dividend);
                    qw_d    = '0;
                    k_d     = FIRST_STEP;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                w_d  = w_step;
                qw_d = qw_q | (QUOTIENT_W'(q_bit) << k_q);
                if (k_q == '0) begin
                    // Last step: publish results on the same edge we enter done.
                    quotient_d  = qw_d;
                    remainder_d = w_step;
                    state_d     = StDone;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_divide_10.sv
module tb_divide_10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] dividend;
    logic [9:0]  quotient;
    logic [13:0] remainder;
    logic        done;

    int tests;
    int fails;

    divide_10 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] d;
        logic [9:0]  q;
        logic [13:0] r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic int ref_q(input int d);
        int q;
        q = d / 10;
        return (q > 1023) ? 1023 : q;
    endfunction

    function automatic int ref_r(input int d);
        return d - 10 * ref_q(d);
    endfunction

    // Launch one operation from idle, scramble dividend while busy, and wait
    // for done. Returns results, latency and whether outputs held while busy.
    task automatic run_op(input logic [13:0] d, output int q, output int r,
                          output int lat, output int held_bad);
        logic [9:0]  q0;
        logic [13:0] r0;
        @(negedge clk);
        q0       = quotient;
        r0       = remainder;
        dividend = d;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 14'($urandom);
        lat      = 0;
        held_bad = 0;
        while (!done && lat < 30) begin
            if (quotient !== q0 || remainder !== r0) held_bad = 1;
            @(posedge clk);
            lat++;
            @(negedge clk);
            dividend = 14'($urandom);
        end
        if (!done) lat = 99;
        q = int'(quotient);
        r = int'(remainder);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int q, r, lat, hb;
        int pulses;
        logic [13:0] d;

        tests = 0;
        fails = 0;

        vecs[0] = '{d: 14'd351,   q: 10'd35,   r: 14'd1};
        vecs[1] = '{d: 14'd0,     q: 10'd0,    r: 14'd0};
        vecs[2] = '{d: 14'd9,     q: 10'd0,    r: 14'd9};
        vecs[3] = '{d: 14'd10,    q: 10'd1,    r: 14'd0};
        vecs[4] = '{d: 14'd10239, q: 10'd1023, r: 14'd9};
        vecs[5] = '{d: 14'd16383, q: 10'd1023, r: 14'd6153};
        vecs[6] = '{d: 14'd10229, q: 10'd1022, r: 14'd9};
        vecs[7] = '{d: 14'd10230, q: 10'd1023, r: 14'd0};
        vecs[8] = '{d: 14'd10240, q: 10'd1023, r: 14'd10};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].d, q, r, lat, hb);
            check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
            check($sformatf("vec%0d_hold_busy", i), 32'(hb), 32'd0);
        end

        // Results hold through idle.
        repeat (4) @(negedge clk);
        check("idle_hold_quotient", 32'(quotient), 32'd1023);
        check("idle_hold_remainder", 32'(remainder), 32'd10);
        check("idle_no_done", 32'(done), 32'd0);

        // Start held high from reset release: launch at cycles 0, 12, 24, ...
        // Dividend is 351 only on launch edges, random otherwise.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst_n = 1'b1;
                start = 1'b1;
            end
            if (c > 0) begin
                check($sformatf("held_done_c%0d", c), 32'(done), 32'((c % 12) == 11));
                if (done) pulses++;
                if (c >= 11) begin
                    check($sformatf("held_q_c%0d", c), 32'(quotient), 32'd35);
                    check($sformatf("held_r_c%0d", c), 32'(remainder), 32'd1);
                end
            end
            dividend = ((c % 12) == 0) ? 14'd351 : 14'($urandom);
            @(posedge clk);
        end
        check("held_pulse_count", 32'(pulses), 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);

        // Reset during step k=5 discards the operation.
        run_op(14'd777, q, r, lat, hb);
        check("pre_reset_q", 32'(q), 32'd77);
        @(negedge clk);
        dividend = 14'd5000;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midop_reset_q", 32'(quotient), 32'd0);
        check("midop_reset_r", 32'(remainder), 32'd0);
        check("midop_reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midop_no_done", 32'(pulses), 32'd0);
        run_op(14'd123, q, r, lat, hb);
        check("relaunch_q", 32'(q), 32'd12);
        check("relaunch_r", 32'(r), 32'd3);
        check("relaunch_lat", 32'(lat), 32'd10);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            d = 14'($urandom_range(0, 16383));
            run_op(d, q, r, lat, hb);
            check($sformatf("rand%0d_q(d=%0d)", i, d), 32'(q), 32'(ref_q(int'(d))));
            check($sformatf("rand%0d_r(d=%0d)", i, d), 32'(r), 32'(ref_r(int'(d))));
            check($sformatf("rand%0d_identity", i), 32'(q * 10 + r), 32'(d));
            check($sformatf("rand%0d_lat", i), 32'(lat), 32'd10);
            check($sformatf("rand%0d_hold", i), 32'(hb), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
